// File: rtl/vga_timing_gen_if.sv
// Raster-timing bundle shared between the timing generator and every
// consumer (mappers, sprite logic, VGA pin drivers).
interface vga_timing_gen_if;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       hs_d;
    logic       vs_d;
    logic       blank_d;
    logic       frame_start;
    logic       line_start;

    modport master (
        output DrawX, DrawY, blank, hs, vs, hs_d, vs_d, blank_d,
               frame_start, line_start
    );

    modport slave (
        input  DrawX, DrawY, blank, hs, vs, hs_d, vs_d, blank_d,
               frame_start, line_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster generator: pixel/line counters, sync and blank
// decode, start strobes, and a delay line that aligns sync with mapper RGB.
module vga_timing_gen #(
    parameter int   H_VISIBLE  = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_VISIBLE  = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter logic SYNC_POL   = 1'b0,
    parameter int   PIPE_DELAY = 2
) (
    input  logic              vga_clk,
    input  logic              reset,
    vga_timing_gen_if.master  vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);

    logic [9:0] hc;
    logic [9:0] vc;
    logic [9:0] hc_next;
    logic [9:0] vc_next;
    logic       running;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       frame_start;
    logic       line_start;
    logic [PIPE_DELAY-1:0][2:0] pipe;

    // The first edge after reset presents (0,0) with live decode, so the
    // counters hold at zero until the running flag is set.
    always_comb begin
        hc_next = '0;
        vc_next = '0;
        if (running) begin
            if (hc == H_LAST) begin
                hc_next = '0;
                vc_next = (vc == V_LAST) ? 10'd0 : vc + 10'd1;
            end else begin
                hc_next = hc + 10'd1;
                vc_next = vc;
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            running     <= 1'b0;
            hc          <= '0;
            vc          <= '0;
            blank       <= 1'b0;
            hs          <= ~SYNC_POL;
            vs          <= ~SYNC_POL;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            running     <= 1'b1;
            hc          <= hc_next;
            vc          <= vc_next;
            blank       <= ({1'b0, hc_next} < H_VIS) && ({1'b0, vc_next} < V_VIS);
            hs          <= (({1'b0, hc_next} >= HS_START) && ({1'b0, hc_next} < HS_END))
                           ? SYNC_POL : ~SYNC_POL;
            vs          <= (({1'b0, vc_next} >= VS_START) && ({1'b0, vc_next} < VS_END))
                           ? SYNC_POL : ~SYNC_POL;
            frame_start <= (hc_next == 10'd0) && (vc_next == 10'd0);
            line_start  <= (hc_next == 10'd0);
        end
    end

    // Delay line carrying {hs, vs, blank}; stage PIPE_DELAY-1 feeds the pins.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            for (int i = 0; i < PIPE_DELAY; i++) begin
                pipe[i] <= {~SYNC_POL, ~SYNC_POL, 1'b0};
            end
        end else begin
            pipe[0] <= {hs, vs, blank};
            for (int i = 1; i < PIPE_DELAY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign vga.DrawX       = hc;
    assign vga.DrawY       = vc;
    assign vga.blank       = blank;
    assign vga.hs          = hs;
    assign vga.vs          = vs;
    assign vga.frame_start = frame_start;
    assign vga.line_start  = line_start;
    assign vga.hs_d        = pipe[PIPE_DELAY-1][2];
    assign vga.vs_d        = pipe[PIPE_DELAY-1][1];
    assign vga.blank_d     = pipe[PIPE_DELAY-1][0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a pixel-index raster model queues the
// expected outputs per cycle, a negedge monitor pops and compares them.
module tb_vga_timing_gen;

    localparam int   H_VISIBLE  = 640;
    localparam int   H_FP       = 16;
    localparam int   H_SYNC     = 96;
    localparam int   H_BP       = 48;
    localparam int   V_VISIBLE  = 20;
    localparam int   V_FP       = 2;
    localparam int   V_SYNC     = 2;
    localparam int   V_BP       = 3;
    localparam logic SYNC_POL   = 1'b0;
    localparam int   PIPE_DELAY = 2;

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int FRAME   = H_TOTAL * V_TOTAL;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       blank;
        logic       hs;
        logic       vs;
        logic       hs_d;
        logic       vs_d;
        logic       blank_d;
        logic       frame_start;
        logic       line_start;
    } exp_t;

    logic vga_clk = 1'b0;
    logic reset   = 1'b1;

    vga_timing_gen_if vif ();

    vga_timing_gen #(
        .H_VISIBLE (H_VISIBLE),
        .H_FP      (H_FP),
        .H_SYNC    (H_SYNC),
        .H_BP      (H_BP),
        .V_VISIBLE (V_VISIBLE),
        .V_FP      (V_FP),
        .V_SYNC    (V_SYNC),
        .V_BP      (V_BP),
        .SYNC_POL  (SYNC_POL),
        .PIPE_DELAY(PIPE_DELAY)
    ) dut (
        .vga_clk(vga_clk),
        .reset  (reset),
        .vga    (vif)
    );

    always #20 vga_clk = ~vga_clk;

    exp_t       sb[$];
    logic [2:0] past[$];
    bit         in_reset = 1'b1;
    int         cur_p    = 0;
    int         tests    = 0;
    int         fails    = 0;
    int         cycle    = 0;
    int         hs_low, vs_low, blank_cnt, blank_d_cnt, fs_cnt, ls_cnt;

    // Reference model: position is a linear pixel index within the frame.
    function automatic exp_t model_step(input bit r);
        exp_t       e;
        logic [2:0] dly;
        int         x, y;
        if (r) begin
            in_reset = 1'b1;
            past.delete();
            for (int i = 0; i < PIPE_DELAY; i++) past.push_back({~SYNC_POL, ~SYNC_POL, 1'b0});
            e = '{x: 10'd0, y: 10'd0, blank: 1'b0, hs: ~SYNC_POL, vs: ~SYNC_POL,
                  hs_d: ~SYNC_POL, vs_d: ~SYNC_POL, blank_d: 1'b0,
                  frame_start: 1'b0, line_start: 1'b0};
            return e;
        end
        cur_p    = in_reset ? 0 : (cur_p + 1) % FRAME;
        in_reset = 1'b0;
        x = cur_p % H_TOTAL;
        y = cur_p / H_TOTAL;
        e.x           = 10'(x);
        e.y           = 10'(y);
        e.blank       = (x < H_VISIBLE) && (y < V_VISIBLE);
        e.hs          = (x >= H_VISIBLE + H_FP && x < H_VISIBLE + H_FP + H_SYNC) ? SYNC_POL : ~SYNC_POL;
        e.vs          = (y >= V_VISIBLE + V_FP && y < V_VISIBLE + V_FP + V_SYNC) ? SYNC_POL : ~SYNC_POL;
        e.frame_start = (cur_p == 0);
        e.line_start  = (x == 0);
        dly = past.pop_front();
        past.push_back({e.hs, e.vs, e.blank});
        e.hs_d    = dly[2];
        e.vs_d    = dly[1];
        e.blank_d = dly[0];
        return e;
    endfunction

    task automatic apply_stimulus(input bit r);
        reset = r;
        @(posedge vga_clk);
        sb.push_back(model_step(r));
        #1;
    endtask

    task automatic check_output(input exp_t e);
        exp_t got;
        got = {vif.DrawX, vif.DrawY, vif.blank, vif.hs, vif.vs, vif.hs_d, vif.vs_d,
               vif.blank_d, vif.frame_start, vif.line_start};
        tests++;
        if (got !== e) begin
            fails++;
            $display("[TB] FAIL pixel cycle=%0d got x=%0d y=%0d flags=%b expected x=%0d y=%0d flags=%b",
                     cycle, got.x, got.y, got[7:0], e.x, e.y, e[7:0]);
        end
    endtask

    task automatic check_count(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("[TB] FAIL %s got %0d expected %0d", name, got, want);
        end
    endtask

    always @(negedge vga_clk) begin
        cycle++;
        if (sb.size() > 0) begin
            check_output(sb.pop_front());
            if (vif.hs === SYNC_POL)  hs_low++;
            if (vif.vs === SYNC_POL)  vs_low++;
            if (vif.blank === 1'b1)   blank_cnt++;
            if (vif.blank_d === 1'b1) blank_d_cnt++;
            if (vif.frame_start === 1'b1) fs_cnt++;
            if (vif.line_start === 1'b1)  ls_cnt++;
        end
    end

    task automatic clear_counts();
        hs_low = 0; vs_low = 0; blank_cnt = 0; blank_d_cnt = 0; fs_cnt = 0; ls_cnt = 0;
    endtask

    initial begin
        int guard;
        clear_counts();
        repeat (5) apply_stimulus(1'b1);
        clear_counts();

        // One whole frame starting at the first post-reset pixel.
        repeat (FRAME) apply_stimulus(1'b0);
        @(negedge vga_clk);
        #1;
        check_count("frame_start pulses", fs_cnt, 1);
        check_count("line_start pulses", ls_cnt, V_TOTAL);
        check_count("hs asserted cycles", hs_low, H_SYNC * V_TOTAL);
        check_count("vs asserted cycles", vs_low, V_SYNC * H_TOTAL);
        check_count("blank visible cycles", blank_cnt, H_VISIBLE * V_VISIBLE);
        check_count("blank_d visible cycles", blank_d_cnt, H_VISIBLE * V_VISIBLE);

        repeat (1000) apply_stimulus(1'b0);

        // Mid-frame reset while DrawX=300, DrawY=10.
        guard = 0;
        while (cur_p != 10 * H_TOTAL + 300 && guard < 2 * FRAME) begin
            apply_stimulus(1'b0);
            guard++;
        end
        check_count("reach mid-frame point", guard < 2 * FRAME ? 1 : 0, 1);
        apply_stimulus(1'b1);
        repeat (500) apply_stimulus(1'b0);

        for (int seg = 0; seg < 6; seg++) begin
            repeat ($urandom_range(50, 3000)) apply_stimulus(1'b0);
            repeat ($urandom_range(1, 3)) apply_stimulus(1'b1);
        end
        repeat (200) apply_stimulus(1'b0);

        @(negedge vga_clk);
        #1;
        check_count("scoreboard drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
